// File: rtl/not_result_checker.sv
// not_result_checker: watches the stimulus and output of an N-bit inverter. After a_in has been
// stable for SETTLE cycles it checks y_in == ~a_in once. A run performs NUM_CHECKS such checks,
// counts them and their mismatches, captures the first failing pair, and then reports pass/fail.
module not_result_checker #(
    parameter int unsigned WIDTH      = 2,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned NUM_CHECKS = 10,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_y
);

    // The settle counter only has to reach SETTLE-1.
    localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e           state_q;
    logic [SCW-1:0]   settle_cnt_q;
    logic [WIDTH-1:0] a_prev_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] check_count_q;
    logic [CNT_W-1:0] fail_count_q;
    logic             ff_valid_q;
    logic [WIDTH-1:0] ff_a_q;
    logic [WIDTH-1:0] ff_y_q;

    logic             change;
    logic             mismatch;
    logic [CNT_W-1:0] check_inc;
    logic [CNT_W-1:0] fail_inc;

    // Input-change detect, compare result and next counter values.
    always_comb begin
        change    = (a_in != a_prev_q);
        mismatch  = (y_in != ~a_in);
        check_inc = check_count_q + CNT_W'(1);
        fail_inc  = (fail_count_q == {CNT_W{1'b1}}) ? fail_count_q
                                                    : fail_count_q + CNT_W'(1);
    end

    // Run sequencer: settle, compare, count, and hold results in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            settle_cnt_q  <= '0;
            a_prev_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            check_count_q <= '0;
            fail_count_q  <= '0;
            ff_valid_q    <= 1'b0;
            ff_a_q        <= '0;
            ff_y_q        <= '0;
        end else begin
            a_prev_q <= a_in;
            unique case (state_q)
                StIdle: begin
                    check_count_q <= '0;
                    fail_count_q  <= '0;
                    ff_valid_q    <= 1'b0;
                    ff_a_q        <= '0;
                    ff_y_q        <= '0;
                    settle_cnt_q  <= '0;
                    if (start) begin
                        state_q <= StSettle;
                        busy_q  <= 1'b1;
                    end
                end
                StSettle: begin
                    // Any input movement restarts the settle window.
                    if (change) begin
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q == SCW'(SETTLE - 1)) begin
                        state_q <= StCheck;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SCW'(1);
                    end
                end
                StCheck: begin
                    check_count_q <= check_inc;
                    settle_cnt_q  <= '0;
                    if (mismatch) begin
                        fail_count_q <= fail_inc;
                        if (!ff_valid_q) begin
                            ff_valid_q <= 1'b1;
                            ff_a_q     <= a_in;
                            ff_y_q     <= y_in;
                        end
                    end
                    if (check_inc == CNT_W'(NUM_CHECKS)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !mismatch && (fail_count_q == '0);
                    end else begin
                        state_q <= StSettle;
                    end
                end
                StDone: begin
                    if (start) begin
                        state_q       <= StSettle;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        check_count_q <= '0;
                        fail_count_q  <= '0;
                        ff_valid_q    <= 1'b0;
                        ff_a_q        <= '0;
                        ff_y_q        <= '0;
                        settle_cnt_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign check_count      = check_count_q;
    assign fail_count       = fail_count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_a     = ff_a_q;
    assign first_fail_y     = ff_y_q;

endmodule

// File: tb/tb_not_result_checker.sv
// Bench for not_result_checker: expected compares are queued as stimulus is driven and retired
// each time the checker's check_count advances.
module tb_not_result_checker;

    logic       clk;
    logic       rst_n;
    logic       start, start_sat, start_one;
    logic [1:0] a_in, y_in;

    logic       busy, done, pass, ffv;
    logic [7:0] check_count, fail_count;
    logic [1:0] ffa, ffy;

    logic       busy_sat, done_sat, pass_sat, ffv_sat;
    logic [1:0] cc_sat, fc_sat, ffa_sat, ffy_sat;

    logic       busy_one, done_one, pass_one, ffv_one;
    logic [7:0] cc_one, fc_one;
    logic [1:0] ffa_one, ffy_one;

    not_result_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .y_in(y_in),
        .busy(busy), .done(done), .pass(pass), .check_count(check_count),
        .fail_count(fail_count), .first_fail_valid(ffv), .first_fail_a(ffa),
        .first_fail_y(ffy)
    );

    not_result_checker #(.WIDTH(2), .SETTLE(2), .NUM_CHECKS(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_sat), .a_in(a_in), .y_in(y_in),
        .busy(busy_sat), .done(done_sat), .pass(pass_sat), .check_count(cc_sat),
        .fail_count(fc_sat), .first_fail_valid(ffv_sat), .first_fail_a(ffa_sat),
        .first_fail_y(ffy_sat)
    );

    not_result_checker #(.WIDTH(2), .SETTLE(1), .NUM_CHECKS(1), .CNT_W(8)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start_one), .a_in(a_in), .y_in(y_in),
        .busy(busy_one), .done(done_one), .pass(pass_one), .check_count(cc_one),
        .fail_count(fc_one), .first_fail_valid(ffv_one), .first_fail_a(ffa_one),
        .first_fail_y(ffy_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] y;
        logic       bad;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;
    int   cc_m, fc_m;
    logic ffv_m;
    logic [1:0] ffa_m, ffy_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb_q.delete();
        cc_m  = 0;
        fc_m  = 0;
        ffv_m = 1'b0;
        ffa_m = 2'b00;
        ffy_m = 2'b00;
    endtask

    task automatic push_exp(input logic [1:0] a, input logic [1:0] y);
        exp_t e;
        e.a   = a;
        e.y   = y;
        e.bad = (y != ~a);
        sb_q.push_back(e);
    endtask

    // Step until check_count moves (bounded), then retire one expected compare.
    task automatic wait_compare(input int budget, output int steps);
        logic [7:0] prev_cc;
        exp_t       e;
        prev_cc = check_count;
        steps   = 0;
        while (check_count == prev_cc && steps < budget) begin
            step();
            steps++;
        end
        if (check_count == prev_cc) begin
            check_eq("cmp_timeout", 32'(check_count), 32'(prev_cc) + 1);
        end else if (sb_q.size() == 0) begin
            check_eq("unexpected_cmp", 32'(check_count), 32'(prev_cc));
        end else begin
            e = sb_q.pop_front();
            cc_m++;
            if (e.bad && fc_m < 255) fc_m++;
            if (e.bad && !ffv_m) begin
                ffv_m = 1'b1;
                ffa_m = e.a;
                ffy_m = e.y;
            end
            check_eq("check_count", 32'(check_count), 32'(cc_m));
            check_eq("fail_count", 32'(fail_count), 32'(fc_m));
            check_eq("first_fail_valid", 32'(ffv), 32'(ffv_m));
            check_eq("first_fail_a", 32'(ffa), 32'(ffa_m));
            check_eq("first_fail_y", 32'(ffy), 32'(ffy_m));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_pass"}, 32'(pass), 0);
        check_eq({tag, "_cc"}, 32'(check_count), 0);
        check_eq({tag, "_fc"}, 32'(fail_count), 0);
        check_eq({tag, "_ffv"}, 32'(ffv), 0);
        check_eq({tag, "_ffa"}, 32'(ffa), 0);
        check_eq({tag, "_ffy"}, 32'(ffy), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [1:0] seq [10];
    int         steps;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        clear_model();
        rst_n     = 1'b1;
        start     = 1'b0;
        start_sat = 1'b0;
        start_one = 1'b0;
        a_in      = 2'b00;
        y_in      = 2'b11;
        seq       = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

        // Reset state
        #2 rst_n = 1'b0;
        step();
        step();
        check_zero_outputs("reset");
        #2 rst_n = 1'b1;
        step();

        // Correct inverter, A held 0: compares every SETTLE+1 cycles
        for (int i = 0; i < 10; i++) push_exp(2'b00, 2'b11);
        pulse_start();
        check_eq("t1_busy", 32'(busy), 1);
        check_eq("t1_done", 32'(done), 0);
        for (int i = 0; i < 10; i++) begin
            wait_compare(40, steps);
            check_eq("t1_gap", 32'(steps), 3);
        end
        check_eq("t1_done_end", 32'(done), 1);
        check_eq("t1_pass", 32'(pass), 1);
        check_eq("t1_busy_end", 32'(busy), 0);

        // Y stuck at 11, start from DONE clears results
        clear_model();
        a_in = seq[0];
        pulse_start();
        check_eq("t2_cc_clear", 32'(check_count), 0);
        check_eq("t2_done_drop", 32'(done), 0);
        check_eq("t2_pass_drop", 32'(pass), 0);
        check_eq("t2_busy", 32'(busy), 1);
        for (int i = 0; i < 10; i++) begin
            a_in = seq[i];
            push_exp(seq[i], 2'b11);
            wait_compare(40, steps);
        end
        check_eq("t2_fc_total", 32'(fail_count), 6);
        check_eq("t2_pass", 32'(pass), 0);
        check_eq("t2_done", 32'(done), 1);
        check_eq("t2_ffa", 32'(ffa), 1);
        check_eq("t2_ffy", 32'(ffy), 3);

        // A toggling every cycle blocks any compare
        clear_model();
        a_in = 2'b00;
        y_in = 2'b11;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            a_in = a_in ^ 2'b01;
            step();
        end
        check_eq("t3_cc_none", 32'(check_count), 0);
        check_eq("t3_busy", 32'(busy), 1);
        y_in = ~a_in;
        push_exp(a_in, ~a_in);
        wait_compare(40, steps);
        check_eq("t3_first_gap", 32'(steps), 3);
        for (int i = 0; i < 3; i++) begin
            push_exp(a_in, ~a_in);
            wait_compare(40, steps);
        end
        check_eq("t3_cc4", 32'(check_count), 4);

        // Asynchronous reset between edges aborts the run at once
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        #2 rst_n = 1'b1;
        clear_model();
        step();

        // Full run after reset; start while busy at check 5 is ignored
        a_in = 2'b10;
        y_in = 2'b01;
        for (int i = 0; i < 10; i++) push_exp(2'b10, 2'b01);
        pulse_start();
        for (int i = 0; i < 5; i++) wait_compare(40, steps);
        pulse_start();
        check_eq("t4_ignore_cc", 32'(check_count), 5);
        check_eq("t4_ignore_busy", 32'(busy), 1);
        wait_compare(40, steps);
        check_eq("t4_gap_after_ignore", 32'(steps), 2);
        for (int i = 0; i < 4; i++) wait_compare(40, steps);
        check_eq("t4_cc10", 32'(check_count), 10);
        check_eq("t4_done", 32'(done), 1);
        check_eq("t4_pass", 32'(pass), 1);

        // Narrow counters: failing output, no wrap
        a_in      = 2'b01;
        y_in      = 2'b11;
        start_sat = 1'b1;
        step();
        start_sat = 1'b0;
        steps     = 0;
        while (!done_sat && steps < 60) begin
            step();
            steps++;
        end
        check_eq("sat_done", 32'(done_sat), 1);
        check_eq("sat_cc", 32'(cc_sat), 3);
        check_eq("sat_fc", 32'(fc_sat), 3);
        check_eq("sat_pass", 32'(pass_sat), 0);

        // NUM_CHECKS=1, SETTLE=1: done two cycles after start
        y_in      = 2'b10;
        start_one = 1'b1;
        step();
        start_one = 1'b0;
        step();
        check_eq("one_done_early", 32'(done_one), 0);
        step();
        check_eq("one_done", 32'(done_one), 1);
        check_eq("one_pass", 32'(pass_one), 1);
        check_eq("one_cc", 32'(cc_one), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/not_result_checker.md
Name: not_result_checker

Overview:
- Downstream checking stage for the 2-bit inverter: watches the stimulus vector driven into the inverter and the inverter's output, and checks Y == ~A once the input has been stable for a settle window.
- Runs a fixed number of checks per start, counts checks and mismatches, captures the first failing pair, then reports pass/fail.
- Sits beside the device under test in benches and on-board self-test, replacing manual waveform inspection.

Parameters:
- WIDTH, 2, width of the checked vector (A and Y).
- SETTLE, 2, consecutive cycles a_in must be unchanged before a compare; minimum 1.
- NUM_CHECKS, 10, compares per run; range 1..2^CNT_W-1.
- CNT_W, 8, width of the check and fail counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- a_in  in  WIDTH  stimulus vector fed to the inverter.
- y_in  in  WIDTH  inverter output.
- busy  out  1  high while a run is in progress (SETTLE or CHECK).
- done  out  1  high in DONE until the next start.
- pass  out  1  done && fail_count == 0.
- check_count  out  CNT_W  compares performed this run.
- fail_count  out  CNT_W  mismatches this run; saturates at all-ones.
- first_fail_valid  out  1  a mismatch has been captured this run.
- first_fail_a  out  WIDTH  a_in at the first mismatch.
- first_fail_y  out  WIDTH  y_in at the first mismatch.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; settle counter 0; a_prev 0. Reset mid-run aborts the run with no partial results kept.
- All outputs are registered. a_prev <= a_in on every clock edge. change = (a_in != a_prev).
- IDLE:
  - start -> SETTLE.
  - Clear check_count, fail_count, first_fail_* and the settle counter.
- SETTLE:
  - If change, the settle counter loads 0; otherwise it increments.
  - When the counter reaches SETTLE-1 with no change, go to CHECK on the next edge.
  - With a stable input, SETTLE occupies exactly SETTLE cycles.
- CHECK (one cycle):
  - Compare y_in against ~a_in bitwise.
  - check_count += 1.
  - On mismatch: fail_count += 1 (saturating). If first_fail_valid is 0, capture a_in and y_in and set first_fail_valid.
  - If the new check_count == NUM_CHECKS, go to DONE; otherwise go to SETTLE with the counter at 0.
  - If change is high in the CHECK cycle, the compare still happens and the next SETTLE restarts from 0.
- DONE:
  - done = 1 and pass valid; counters and first_fail_* hold.
  - start -> clear all results and enter SETTLE; done drops on that edge.
- Check period with a stable input: SETTLE+1 cycles per compare. The first compare happens in cycle start+SETTLE+1, and its result is visible after that edge.
- start while busy is ignored, with no restart and no counter change.
- Equal consecutive vectors (for example A = 0 four times) are each checked. A check never waits for an input change.
- Counter width rule: check_count never exceeds NUM_CHECKS. fail_count ≤ check_count, saturating at 2^CNT_W-1.

Test Plan:
- Correct inverter, defaults, start at cycle 0, A held 0 → 10 compares at cycles 3,6,…,30. done rises after the cycle-30 compare, with pass=1, check_count=10, fail_count=0, first_fail_valid=0.
- Y stuck at 2'b11, A sequence 0,0,0,0,1,1,1,2,2,3 changing every 3 cycles → fail_count=6 (A=1,2,3 entries fail), pass=0, first_fail_a=2'b01, first_fail_y=2'b11.
- A toggles 0↔1 every cycle for 20 cycles after start → no compare occurs (check_count stays 0, busy=1). Once A is held, the first compare comes SETTLE+1 cycles after the last change.
- rst_n pulsed low mid-run after 4 compares, asynchronously between edges → all outputs are 0 immediately. A subsequent start runs a full 10 compares from zero.
- start pulsed again while busy at check 5 → ignored, and the run completes with check_count=10. start in DONE → results clear and a new run begins.
- CNT_W=2, NUM_CHECKS=3, with a failing output → fail_count=3 and check_count=3 with no wrap. A separate run with NUM_CHECKS=1 and SETTLE=1 gives done after 2 cycles.
